video_timing_pattern_gen: RTL

Source stage of the ISP chain. It generates raster timing (`vs_o`/`hs_o`/`de_o`) and a selectable test pattern on `data_o`, in the same stream format the downstream crop/ISP stages consume. It is used for bring-up and for regression of downstream stages without a sensor attached. Starting and stopping are frame-aligned, so downstream stages never see a partial frame.

---
 rtl/video_timing_pattern_gen.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/video_timing_pattern_gen.sv
// Raster timing and test-pattern source for the ISP chain.
// Starts and stops only on frame boundaries; all outputs registered one cycle after (hc, vc).
module video_timing_pattern_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_BITS   = 12,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            pattern_sel_i,
  input  logic [DATA_WIDTH-1:0] solid_i,
  output logic                  vs_o,
  output logic                  hs_o,
  output logic                  de_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CNT_BITS-1:0]   x_o,
  output logic [CNT_BITS-1:0]   y_o,
  output logic                  frame_start_o
);
  localparam int CH      = DATA_WIDTH / 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_BITS-1:0] HA  = CNT_BITS'(H_ACTIVE);
  localparam logic [CNT_BITS-1:0] HS0 = CNT_BITS'(H_ACTIVE + H_FP);
  localparam logic [CNT_BITS-1:0] HS1 = CNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_BITS-1:0] HL  = CNT_BITS'(H_TOTAL - 1);
  localparam logic [CNT_BITS-1:0] VA  = CNT_BITS'(V_ACTIVE);
  localparam logic [CNT_BITS-1:0] VS0 = CNT_BITS'(V_ACTIVE + V_FP);
  localparam logic [CNT_BITS-1:0] VS1 = CNT_BITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_BITS-1:0] VL  = CNT_BITS'(V_TOTAL - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_BITS-1:0]   r_hc, r_vc, w_hc_nxt, w_vc_nxt;
  logic                  r_stop_pend, w_stop_nxt, w_stop_req;
  logic [1:0]            r_pat, w_pat;
  logic [DATA_WIDTH-1:0] r_solid, w_solid, w_pix;
  logic                  w_eol, w_eof, w_origin, w_run;
  logic                  w_de, w_hs_act, w_vs_act;
  logic [2:0]            w_bar;

  assign w_run    = (r_state == S_RUN);
  assign w_eol    = (r_hc == HL);
  assign w_eof    = w_eol && (r_vc == VL);
  assign w_origin = (r_hc == '0) && (r_vc == '0);
  assign w_de     = (r_hc < HA) && (r_vc < VA);
  assign w_hs_act = (r_hc >= HS0) && (r_hc < HS1);
  assign w_vs_act = (r_vc >= VS0) && (r_vc < VS1);

  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_vc_nxt    = r_vc;
    w_stop_nxt  = r_stop_pend;
    w_stop_req  = r_stop_pend | ~en_i;
    case (r_state)
      S_IDLE: begin
        w_hc_nxt   = '0;
        w_vc_nxt   = '0;
        w_stop_nxt = 1'b0;
        if (en_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_stop_nxt = w_stop_req;
        if (w_eol) begin
          w_hc_nxt = '0;
          w_vc_nxt = w_eof ? '0 : r_vc + 1'b1;
        end else begin
          w_hc_nxt = r_hc + 1'b1;
        end
        // en_i returning high mid-frame does not cancel a pending stop
        if (w_eof && w_stop_req) begin
          w_state_nxt = S_IDLE;
          w_stop_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pattern selection takes effect on the first pixel of the frame it is latched in
  assign w_pat   = (w_run && w_origin) ? pattern_sel_i : r_pat;
  assign w_solid = (w_run && w_origin) ? solid_i : r_solid;

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++)
      if (r_hc >= CNT_BITS'((k * H_ACTIVE + 7) / 8)) w_bar = w_bar + 3'd1;
  end

  // Bar colours white..black map to R = ~bar[1], G = ~bar[2], B = ~bar[0]
  always_comb begin
    w_pix = '0;
    case (w_pat)
      2'd0: w_pix = {{CH{~w_bar[1]}}, {CH{~w_bar[2]}}, {CH{~w_bar[0]}}};
      2'd1: w_pix = {3{r_hc[CH-1:0]}};
      2'd2: w_pix = (r_hc[CHECK_LOG2] ^ r_vc[CHECK_LOG2]) ? '0 : '1;
      default: w_pix = w_solid;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_hc        <= '0;
      r_vc        <= '0;
      r_stop_pend <= 1'b0;
      r_pat       <= '0;
      r_solid     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hc        <= w_hc_nxt;
      r_vc        <= w_vc_nxt;
      r_stop_pend <= w_stop_nxt;
      if (w_run && w_origin) begin
        r_pat   <= pattern_sel_i;
        r_solid <= solid_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vs_o          <= ~VS_POL;
      hs_o          <= ~HS_POL;
      de_o          <= 1'b0;
      data_o        <= '0;
      x_o           <= '0;
      y_o           <= '0;
      frame_start_o <= 1'b0;
    end else begin
      vs_o          <= (w_run && w_vs_act) ? VS_POL : ~VS_POL;
      hs_o          <= (w_run && w_hs_act) ? HS_POL : ~HS_POL;
      de_o          <= w_run && w_de;
      data_o        <= (w_run && w_de) ? w_pix : '0;
      x_o           <= (w_run && w_de) ? r_hc : '0;
      y_o           <= (w_run && w_de) ? r_vc : '0;
      frame_start_o <= w_run && w_origin;
    end
  end
endmodule
